// File: rtl/sb_pair_pkg.sv
// sb_pair_pkg: shared types and helpers for the scoreboard pair aligner.
//   sb_state_e : aligner FSM states
//   SB_*_DEF   : default data / counter widths
//   sat_inc    : saturating increment, evaluated at 64 bits so any counter width up to 64 fits
package sb_pair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sb_state_e;

  localparam int unsigned SB_SIZE_DATA_DEF = 8;
  localparam int unsigned SB_CNT_W_DEF     = 16;
  localparam int unsigned SB_SAT_W         = 64;

  function automatic logic [SB_SAT_W-1:0] sat_inc(input logic [SB_SAT_W-1:0] cnt,
                                                  input logic [SB_SAT_W-1:0] max);
    return (cnt >= max) ? cnt : cnt + 64'd1;
  endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// sb_sync_fifo: first-word-fall-through synchronous queue of expected words.
//   clk_i, rst_n_i : clock, async active-low reset (empties the queue)
//   push_i/data_i  : write data_i at tail
//   pop_i          : advance head
//   data_o         : current head word (valid while !empty_o)
//   full_o/empty_o : occupancy status
// The caller only pushes when !full_o (or when popping the same cycle) and only
// pops when !empty_o. Pointers carry one extra wrap bit to tell full from empty.
module sb_sync_fifo #(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push_i,
  input  logic [SIZE_DATA-1:0] data_i,
  input  logic                 pop_i,
  output logic [SIZE_DATA-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [SIZE_DATA-1:0] mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = push_i ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_i  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reset empties the queue through the pointers.
  // A push while full only happens together with a pop, so it overwrites
  // the head slot after its word has already been consumed this cycle.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sb_pair_aligner.sv
// sb_pair_aligner: queues expected words and pairs each with the next DUT word,
// presenting registered (expect, dut) pairs to the scoreboard.
//   i_clk, i_rst_n              : clock, async active-low reset
//   i_exp_valid, i_exp_data     : expected word push;  o_exp_full: queue full
//   i_dut_valid, i_dut_data     : DUT word to pair with queue head
//   i_end_of_test               : stimulus finished
//   o_pair_valid, o_expect_data,
//   o_data_out, o_match         : registered pair strobe and contents
//   o_is_finish                 : sticky, one cycle after entering DONE
//   o_overflow/o_underflow/o_timeout : sticky error flags
//   o_pair_count, o_err_count   : saturating pair / mismatch counters
// Optional build macro: SB_PAIR_STOP_ON_MISMATCH_EN -- first mismatching pair ends the test.
//
// state | meaning
// IDLE  | after reset, waiting for first traffic
// RUN   | pairing traffic
// DRAIN | end of test seen, waiting for queue to empty (bounded by TIMEOUT)
// DONE  | terminal until reset; inputs ignored
module sb_pair_aligner
  import sb_pair_pkg::*;
#(
  parameter int unsigned SIZE_DATA = SB_SIZE_DATA_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = SB_CNT_W_DEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_exp_valid,
  input  logic [SIZE_DATA-1:0] i_exp_data,
  output logic                 o_exp_full,
  input  logic                 i_dut_valid,
  input  logic [SIZE_DATA-1:0] i_dut_data,
  input  logic                 i_end_of_test,
  output logic                 o_pair_valid,
  output logic [SIZE_DATA-1:0] o_expect_data,
  output logic [SIZE_DATA-1:0] o_data_out,
  output logic                 o_match,
  output logic                 o_is_finish,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_timeout,
  output logic [CNT_W-1:0]     o_pair_count,
  output logic [CNT_W-1:0]     o_err_count
);

  localparam int unsigned      TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_state_e            state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 tmo_hit;
  logic                 fifo_full, fifo_empty;
  logic [SIZE_DATA-1:0] fifo_head;
  logic                 active, push, pop, pop_mismatch, stop_now;

  logic                 pair_valid_q, pair_valid_d;
  logic [SIZE_DATA-1:0] expect_q, expect_d, data_q, data_d;
  logic                 match_q, match_d;
  logic                 finish_q, finish_d, ovf_q, ovf_d, unf_q, unf_d, tmo_flag_q, tmo_flag_d;
  logic [CNT_W-1:0]     pair_cnt_q, pair_cnt_d, err_cnt_q, err_cnt_d;

  assign active       = (state_q != DONE);
  assign pop          = active && i_dut_valid && !fifo_empty;
  // A pop frees a slot in the same cycle, so a push at full still lands.
  assign push         = active && i_exp_valid && (!fifo_full || pop);
  assign pop_mismatch = pop && (fifo_head != i_dut_data);

`ifdef SB_PAIR_STOP_ON_MISMATCH_EN
  assign stop_now = pop_mismatch;
`else
  assign stop_now = 1'b0;
`endif

  sb_sync_fifo #(.SIZE_DATA(SIZE_DATA), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .push_i  (push),
    .data_i  (i_exp_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // DRAIN timer is a down-counter loaded on entry; terminal count 0 aborts.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_end_of_test)                   state_d = DONE;
        else if (i_exp_valid || i_dut_valid) state_d = RUN;
      end
      RUN: begin
        if (stop_now) begin
          state_d = DONE;
        end else if (i_end_of_test) begin
          state_d = DRAIN;
          tmo_d   = TMO_W'(TIMEOUT - 1);
        end
      end
      DRAIN: begin
        if (stop_now || fifo_empty) begin
          state_d = DONE;
        end else if (tmo_q == '0) begin
          state_d = DONE;
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pair_valid_d = pop;
    expect_d     = pop ? fifo_head : expect_q;
    data_d       = pop ? i_dut_data : data_q;
    match_d      = pop ? !pop_mismatch : match_q;
    pair_cnt_d   = pop ? CNT_W'(sat_inc(SB_SAT_W'(pair_cnt_q), SB_SAT_W'(CNT_MAX))) : pair_cnt_q;
    err_cnt_d    = pop_mismatch ? CNT_W'(sat_inc(SB_SAT_W'(err_cnt_q), SB_SAT_W'(CNT_MAX)))
                                : err_cnt_q;
    finish_d     = finish_q | (state_q == DONE);
    ovf_d        = ovf_q | (active && i_exp_valid && fifo_full && !pop);
    unf_d        = unf_q | (active && i_dut_valid && fifo_empty);
    tmo_flag_d   = tmo_flag_q | tmo_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      pair_valid_q <= 1'b0;
      expect_q     <= '0;
      data_q       <= '0;
      match_q      <= 1'b0;
      finish_q     <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      tmo_flag_q   <= 1'b0;
      pair_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      pair_valid_q <= pair_valid_d;
      expect_q     <= expect_d;
      data_q       <= data_d;
      match_q      <= match_d;
      finish_q     <= finish_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      tmo_flag_q   <= tmo_flag_d;
      pair_cnt_q   <= pair_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_exp_full    = fifo_full;
  assign o_pair_valid  = pair_valid_q;
  assign o_expect_data = expect_q;
  assign o_data_out    = data_q;
  assign o_match       = match_q;
  assign o_is_finish   = finish_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;
  assign o_timeout     = tmo_flag_q;
  assign o_pair_count  = pair_cnt_q;
  assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_sb_pair_aligner.sv
// tb_sb_pair_aligner: directed and randomized stimulus against a queue-based
// reference model; pairs are checked by an independent monitor process.
module tb_sb_pair_aligner;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int TMO   = 8;
  localparam int CMAX  = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_exp_valid = 1'b0;
  logic [DW-1:0] i_exp_data = '0;
  logic          o_exp_full;
  logic          i_dut_valid = 1'b0;
  logic [DW-1:0] i_dut_data = '0;
  logic          i_end_of_test = 1'b0;
  logic          o_pair_valid;
  logic [DW-1:0] o_expect_data, o_data_out;
  logic          o_match, o_is_finish, o_overflow, o_underflow, o_timeout;
  logic [CW-1:0] o_pair_count, o_err_count;

  sb_pair_aligner #(.SIZE_DATA(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_exp_valid(i_exp_valid), .i_exp_data(i_exp_data), .o_exp_full(o_exp_full),
    .i_dut_valid(i_dut_valid), .i_dut_data(i_dut_data), .i_end_of_test(i_end_of_test),
    .o_pair_valid(o_pair_valid), .o_expect_data(o_expect_data), .o_data_out(o_data_out),
    .o_match(o_match), .o_is_finish(o_is_finish), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_timeout(o_timeout),
    .o_pair_count(o_pair_count), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [DW-1:0] e; logic [DW-1:0] d; } pair_t;

  // Reference model: expected-word queue plus test phase and sticky results.
  logic [DW-1:0] m_q[$];
  pair_t         exp_pairs[$];
  bit m_started, m_drain, m_done, m_fin, m_ovf, m_unf, m_tmo, m_pv;
  int m_pcnt, m_ecnt, m_drain_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_pairs.delete();
    {m_started, m_drain, m_done, m_fin, m_ovf, m_unf, m_tmo, m_pv} = '0;
    m_pcnt = 0; m_ecnt = 0; m_drain_cycles = 0;
  endtask

  // Consequences of one clock edge given this cycle's inputs.
  task automatic model_cycle(input bit ev, input logic [DW-1:0] ed, input bit dv,
                             input logic [DW-1:0] dd, input bit eot);
    int sz;
    bit was_done, pop, push, stop;
    sz = m_q.size();
    was_done = m_done;
    pop = 0; push = 0; stop = 0;
    m_pv = 0;
    if (was_done) m_fin = 1;
    if (!was_done) begin
      if (dv && sz == 0) m_unf = 1;
      if (dv && sz > 0) begin
        pop = 1;
        m_pv = 1;
        exp_pairs.push_back('{e: m_q[0], d: dd});
        if (m_pcnt < CMAX) m_pcnt++;
        if (m_q[0] != dd) begin
          if (m_ecnt < CMAX) m_ecnt++;
`ifdef SB_PAIR_STOP_ON_MISMATCH_EN
          stop = 1;
`endif
        end
      end
      if (ev) begin
        if (sz < DEPTH || pop) push = 1;
        else m_ovf = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(ed);
      if (!m_started) begin
        if (eot) m_done = 1;
        else if (ev || dv) m_started = 1;
      end else if (stop) begin
        m_done = 1;
      end else if (!m_drain) begin
        if (eot) begin m_drain = 1; m_drain_cycles = 0; end
      end else if (sz == 0) begin
        m_done = 1;
      end else begin
        m_drain_cycles++;
        if (m_drain_cycles == TMO) begin m_done = 1; m_tmo = 1; end
      end
    end
  endtask

  task automatic check_state();
    chk("pair_valid", o_pair_valid, m_pv);
    chk("exp_full",   o_exp_full, m_q.size() == DEPTH);
    chk("is_finish",  o_is_finish, m_fin);
    chk("overflow",   o_overflow, m_ovf);
    chk("underflow",  o_underflow, m_unf);
    chk("timeout",    o_timeout, m_tmo);
    chk("pair_count", o_pair_count, m_pcnt);
    chk("err_count",  o_err_count, m_ecnt);
  endtask

  // Called at a falling edge; applies inputs, lets one rising edge pass, checks.
  task automatic cycle(input bit ev, input logic [DW-1:0] ed, input bit dv,
                       input logic [DW-1:0] dd, input bit eot);
    i_exp_valid = ev; i_exp_data = ed;
    i_dut_valid = dv; i_dut_data = dd;
    i_end_of_test = eot;
    model_cycle(ev, ed, dv, dd, eot);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    i_exp_valid = 0; i_dut_valid = 0; i_end_of_test = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pair_valid", o_pair_valid, 0);
    chk("rst_expect",     o_expect_data, 0);
    chk("rst_data",       o_data_out, 0);
    chk("rst_match",      o_match, 0);
    chk("rst_full",       o_exp_full, 0);
    chk("rst_flags",      {o_is_finish, o_overflow, o_underflow, o_timeout}, 0);
    chk("rst_counts",     {o_pair_count, o_err_count}, 0);
    chk("pending_pairs",  exp_pairs.size(), 0);
    model_reset();
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_pair_valid === 1'b1) begin
      if (exp_pairs.size() == 0) begin
        total++; bad++;
        $display("FAIL pair_unexpected: got strobe expect=%0h dut=%0h, required none",
                 o_expect_data, o_data_out);
      end else begin
        pair_t p;
        p = exp_pairs.pop_front();
        chk("pair_expect", o_expect_data, p.e);
        chk("pair_dut",    o_data_out, p.d);
        chk("pair_match",  o_match, p.e == p.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int k;
    model_reset();
    @(negedge clk);
    do_reset();

    // Three matching pairs.
    cycle(1, 8'h11, 0, '0, 0);
    cycle(1, 8'h22, 0, '0, 0);
    cycle(1, 8'h33, 0, '0, 0);
    cycle(0, '0, 1, 8'h11, 0);
    cycle(0, '0, 1, 8'h22, 0);
    cycle(0, '0, 1, 8'h33, 0);
    idle(1);
    chk("t1_pairs", o_pair_count, 3);
    chk("t1_err",   o_err_count, 0);

    // Single mismatch.
    do_reset();
    cycle(1, 8'hA5, 0, '0, 0);
    cycle(0, '0, 1, 8'h5A, 0);
    chk("t2_match", o_match, 0);
    chk("t2_err",   o_err_count, 1);
    idle(1);
`ifdef SB_PAIR_STOP_ON_MISMATCH_EN
    chk("t2_finish_stop", o_is_finish, 1);
`else
    chk("t2_finish_nostop", o_is_finish, 0);
`endif

    // Fill, push+pop at full, then overflow, then drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(8'h40 + i), 0, '0, 0);
    chk("t3_full", o_exp_full, 1);
    cycle(1, 8'hEE, 1, m_q[0], 0);
    chk("t3_pushpop_no_ovf", o_overflow, 0);
    chk("t3_still_full", o_exp_full, 1);
    cycle(1, 8'hEF, 0, '0, 0);
    chk("t3_ovf", o_overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      d = ($urandom_range(3) != 0) ? m_q[0] : DW'($urandom);
      cycle(0, '0, 1, d, 0);
    end
    idle(1);

    // Underflow, then randomized traffic and a clean drain.
    do_reset();
    cycle(0, '0, 1, 8'h77, 0);
    chk("t4_unf",   o_underflow, 1);
    chk("t4_pairs", o_pair_count, 0);
    chk("t4_pv",    o_pair_valid, 0);
    // Same-cycle push and DUT word into an empty queue: no bypass.
    cycle(1, 8'h66, 1, 8'h66, 0);
    chk("t4_nobypass", o_pair_valid, 0);
    for (int i = 0; i < 400; i++) begin
      bit ev, dv;
      ev = ($urandom_range(99) < 50);
      dv = ($urandom_range(99) < 45);
      if (m_q.size() > 0 && $urandom_range(3) != 0) d = m_q[0];
      else d = DW'($urandom);
      cycle(ev, DW'($urandom), dv, d, 0);
    end
    k = 0;
    while (m_q.size() > 0 && k < 40) begin
      cycle(0, '0, 1, m_q[0], 0);
      k++;
    end
    chk("t4_drained", m_q.size(), 0);
    cycle(0, '0, 0, '0, 1);
    k = 0;
    while (o_is_finish !== 1'b1 && k < 20) begin
      idle(1);
      k++;
    end
    chk("t4_finish", o_is_finish, 1);
    // Traffic in DONE is ignored.
    cycle(1, 8'h01, 1, 8'h02, 0);
    cycle(0, '0, 1, 8'h03, 0);
    idle(1);

    // Drain timeout with two words stuck in the queue.
    do_reset();
    cycle(1, 8'hC1, 0, '0, 0);
    cycle(1, 8'hC2, 0, '0, 0);
    cycle(0, '0, 0, '0, 1);
    k = 0;
    while (o_timeout !== 1'b1 && k < 30) begin
      idle(1);
      k++;
    end
    chk("t5_tmo_cycles", k, TMO);
    chk("t5_finish_early", o_is_finish, 0);
    idle(1);
    chk("t5_finish", o_is_finish, 1);

    // Reset in the middle of DRAIN, then a clean follow-up test.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, DW'(8'h90 + i), 0, '0, 0);
    cycle(0, '0, 0, '0, 1);
    idle(2);
    do_reset();
    cycle(1, 8'h42, 0, '0, 0);
    cycle(0, '0, 1, 8'h42, 0);
    chk("t6_match", o_match, 1);
    chk("t6_pairs", o_pair_count, 1);
    idle(2);
    chk("end_pending_pairs", exp_pairs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
